pc_mem_unit: RTL

//  Program counter plus unified 256x8 program/data memory sitting directly upstream of control_unit.

---
 rtl/pc_mem_unit_if.sv | 36 +++
 rtl/pc_mem_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pc_mem_unit_if.sv
// Bus between pc_mem_unit, control_unit and the byte-stream boot loader.
// The master side drives the CPU control strobes and the loader stream.
// The slave side (pc_mem_unit) returns the PC, read data and run/ready status.
interface pc_mem_unit_if;
  // control_unit -> pc_mem_unit
  logic       pc_inc;
  logic       pc_load;
  logic [7:0] pc_next;
  logic       exec_phase;
  logic [7:0] mem_addr;
  logic       mem_write_en;
  logic [7:0] mem_write_data;

  // boot loader stream
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_last;
  logic       prog_ready;

  // pc_mem_unit -> control_unit
  logic       cpu_run;
  logic [7:0] pc;
  logic [7:0] mem_read_data;

  modport master (
    output pc_inc, pc_load, pc_next, exec_phase, mem_addr, mem_write_en, mem_write_data,
    output prog_valid, prog_data, prog_last,
    input  prog_ready, cpu_run, pc, mem_read_data
  );

  modport slave (
    input  pc_inc, pc_load, pc_next, exec_phase, mem_addr, mem_write_en, mem_write_data,
    input  prog_valid, prog_data, prog_last,
    output prog_ready, cpu_run, pc, mem_read_data
  );
endinterface

// File: rtl/pc_mem_unit.sv
// Program counter plus unified 256x8 program/data memory with a boot loader.
// After reset the unit sits in BOOT and accepts a byte stream into memory
// starting at address 0; the CPU is held idle until the stream ends (prog_last
// or the 256th byte), after which the unit stays in RUN until the next reset.
// Memory contents survive reset so a partially loaded image is retained.
module pc_mem_unit #(
  parameter int         MEM_DEPTH = 256,
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter bit         BOOT_EN   = 1'b1
) (
  input logic         clk,
  input logic         arst_n,
  pc_mem_unit_if.slave bus
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] load_ptr_q;
  logic [7:0] pc_q;

  logic       handshake;
  logic       boot_done;
  logic       prog_ready;
  logic       cpu_run;

  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] rd_addr;

  logic [7:0] mem [MEM_DEPTH];

  // State register; reset chooses BOOT or RUN depending on whether the loader is enabled
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      if (BOOT_EN) state_q <= ST_BOOT;
      else         state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode; a loader byte is accepted whenever valid is seen in BOOT
  always_comb begin
    state_d    = state_q;
    prog_ready = 1'b0;
    cpu_run    = 1'b0;
    handshake  = 1'b0;
    boot_done  = 1'b0;
    if (state_q == ST_BOOT) begin
      prog_ready = 1'b1;
      handshake  = bus.prog_valid;
      if (handshake && (bus.prog_last || load_ptr_q == 8'hFF)) begin
        boot_done = 1'b1;
        state_d   = ST_RUN;
      end
    end else begin
      cpu_run = 1'b1;
    end
  end

  // Loader write pointer; wraps to 0 after the 256th byte
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      load_ptr_q <= 8'h00;
    end else if (handshake) begin
      load_ptr_q <= load_ptr_q + 8'd1;
    end
  end

  // Program counter: restarted on leaving BOOT, then load beats increment while running
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q <= RESET_PC;
    end else if (boot_done) begin
      pc_q <= RESET_PC;
    end else if (state_q == ST_RUN) begin
      if (bus.pc_load) begin
        pc_q <= bus.pc_next;
      end else if (bus.pc_inc) begin
        pc_q <= pc_q + 8'd1;
      end
    end
  end

  // Single write port shared by the loader (BOOT) and EXECUTE-phase data stores (RUN);
  // read address follows the loader pointer, the data address or the PC
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_ptr_q;
    mem_wdata = bus.prog_data;
    rd_addr   = load_ptr_q;
    if (state_q == ST_BOOT) begin
      mem_we = handshake;
    end else begin
      mem_waddr = bus.mem_addr;
      mem_wdata = bus.mem_write_data;
      mem_we    = bus.mem_write_en & bus.exec_phase;
      rd_addr   = bus.exec_phase ? bus.mem_addr : pc_q;
    end
  end

  // Memory array is deliberately not reset so contents persist across resets
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.mem_read_data = mem[rd_addr];
  assign bus.pc            = pc_q;
  assign bus.prog_ready    = prog_ready;
  assign bus.cpu_run       = cpu_run;

endmodule
